imm_encoder_loader: RTL

- Inverse of the datapath immediate generator: packs opcode, funct3, register fields and a 32-bit signed immediate into RV32 I/S/B instruction words.
- Writes the encoded words sequentially into instruction memory over a single-cycle write port.
- Used for boot-time program preload and self-test stimulus generation.
- Checks immediate range and alignment, and reports errors instead of writing malformed words.

---
 rtl/imm_encoder_loader.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/imm_encoder_loader.sv
// Encodes RV32 I/S/B instructions from fields plus a signed immediate and
// streams them into instruction memory, rejecting out-of-range or misaligned immediates.
module imm_encoder_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              err_valid,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   word_count,
  output logic              busy
);

  localparam int CNT_W = ADDR_W + 1;

  localparam logic [1:0] FMT_I = 2'b00;
  localparam logic [1:0] FMT_S = 2'b01;
  localparam logic [1:0] FMT_B = 2'b10;

  localparam logic [1:0] ERR_RANGE   = 2'b01;
  localparam logic [1:0] ERR_ALIGN   = 2'b10;
  localparam logic [1:0] ERR_BAD_FMT = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FULL = 2'b10
  } stateT;

  stateT             stateReg;
  stateT             stateNext;

  logic [ADDR_W-1:0] addrReg;
  logic [CNT_W-1:0]  wordCountReg;
  logic              memWeReg;
  logic [ADDR_W-1:0] memAddrReg;
  logic [31:0]       memWdataReg;
  logic              errValidReg;
  logic [1:0]        errCodeReg;

  logic [31:0]       wordI;
  logic [31:0]       wordS;
  logic [31:0]       wordB;
  logic [31:0]       encWord;
  logic              smallOk;
  logic              branchOk;
  logic              reqErr;
  logic [1:0]        reqCode;
  logic              readyInt;
  logic              accept;
  logic              lastWord;

  // Field packing for each format; B drops imm[0] because offsets are halfword aligned.
  always_comb begin
    wordI = {imm[11:0], rs1, funct3, rd, opcode};
    wordS = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
    wordB = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
  end

  // Explicit bounds so an odd value just above the B limit reports range, not alignment.
  always_comb begin
    smallOk  = ($signed(imm) >= -32'sd2048) && ($signed(imm) <= 32'sd2047);
    branchOk = ($signed(imm) >= -32'sd4096) && ($signed(imm) <= 32'sd4094);
  end

  always_comb begin
    reqErr  = 1'b0;
    reqCode = 2'b00;
    encWord = wordI;
    unique case (fmt)
      FMT_I: begin
        encWord = wordI;
        if (!smallOk) begin
          reqErr  = 1'b1;
          reqCode = ERR_RANGE;
        end
      end
      FMT_S: begin
        encWord = wordS;
        if (!smallOk) begin
          reqErr  = 1'b1;
          reqCode = ERR_RANGE;
        end
      end
      FMT_B: begin
        encWord = wordB;
        if (!branchOk) begin
          reqErr  = 1'b1;
          reqCode = ERR_RANGE;
        end else if (imm[0]) begin
          reqErr  = 1'b1;
          reqCode = ERR_ALIGN;
        end
      end
      default: begin
        reqErr  = 1'b1;
        reqCode = ERR_BAD_FMT;
      end
    endcase
  end

  // Control pulses take the cycle, so no request is taken alongside start or finish.
  always_comb begin
    readyInt = (stateReg == RUN) && !start && !finish;
    accept   = in_valid && readyInt;
    lastWord = (wordCountReg == CNT_W'(DEPTH - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    unique case (stateReg)
      IDLE: begin
        if (start) begin
          stateNext = RUN;
        end
      end
      RUN: begin
        if (start) begin
          stateNext = RUN;
        end else if (finish) begin
          stateNext = IDLE;
        end else if (accept && !reqErr && lastWord) begin
          stateNext = FULL;
        end
      end
      FULL: begin
        if (start) begin
          stateNext = RUN;
        end else if (finish) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Rejected requests are consumed but leave the write pointer and count untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      addrReg      <= '0;
      wordCountReg <= '0;
      memWeReg     <= 1'b0;
      memAddrReg   <= '0;
      memWdataReg  <= '0;
      errValidReg  <= 1'b0;
      errCodeReg   <= 2'b00;
    end else begin
      memWeReg    <= 1'b0;
      errValidReg <= 1'b0;
      if (start) begin
        addrReg      <= base_addr;
        wordCountReg <= '0;
      end else if (accept) begin
        if (reqErr) begin
          errValidReg <= 1'b1;
          errCodeReg  <= reqCode;
        end else begin
          memWeReg     <= 1'b1;
          memAddrReg   <= addrReg;
          memWdataReg  <= encWord;
          addrReg      <= addrReg + ADDR_W'(1);
          wordCountReg <= wordCountReg + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    in_ready   = readyInt;
    busy       = (stateReg != IDLE);
    mem_we     = memWeReg;
    mem_addr   = memAddrReg;
    mem_wdata  = memWdataReg;
    err_valid  = errValidReg;
    err_code   = errCodeReg;
    word_count = wordCountReg;
  end

endmodule
